// File: rtl/pipe_idex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register and its
// operand-forwarding selectors.
package pipe_idex_stage_pkg;

    // Architectural register numbers with fixed meaning
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    // Source of an execute-stage operand
    typedef enum logic [1:0] {
        FWD_RF      = 2'd0,
        FWD_EX      = 2'd1,
        FWD_MEM_ALU = 2'd2,
        FWD_MEM_LD  = 2'd3
    } fwd_sel_e;

    // Control fields carried from decode into execute
    typedef struct packed {
        logic [3:0] aluc;
        logic       aluimm;
        logic       shift;
        logic       jal;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       valid;
    } ctrl_t;

    // A bubble writes nothing, touches no memory and is not a real instruction
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Operand forwarding select for one source register: picks the youngest
// in-flight producer (EX, then MEM) or falls back to the register file.
module pipe_fwd_sel
    import pipe_idex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic [RAW-1:0]  src_i,
    input  logic [XLEN-1:0] rf_i,
    input  logic [RAW-1:0]  ern_i,
    input  logic            ewreg_i,
    input  logic            em2reg_i,
    input  logic [XLEN-1:0] ealu_i,
    input  logic [RAW-1:0]  mrn_i,
    input  logic            mwreg_i,
    input  logic            mm2reg_i,
    input  logic [XLEN-1:0] malu_i,
    input  logic [XLEN-1:0] mmo_i,
    output logic [XLEN-1:0] opnd_o
);

    fwd_sel_e sel;
    logic     exHit;
    logic     memHit;

    // A load in EX has no data yet, so it never forwards; register 0 never forwards
    always_comb begin
        exHit  = ewreg_i & ~em2reg_i & (ern_i != RAW'(REG_ZERO)) & (ern_i == src_i);
        memHit = mwreg_i & (mrn_i != RAW'(REG_ZERO)) & (mrn_i == src_i);
        sel    = FWD_RF;
        if (exHit) begin
            sel = FWD_EX;
        end else if (memHit) begin
            sel = mm2reg_i ? FWD_MEM_LD : FWD_MEM_ALU;
        end
    end

    // Four-way operand mux driven by the select above
    always_comb begin
        opnd_o = rf_i;
        case (sel)
            FWD_EX:      opnd_o = ealu_i;
            FWD_MEM_ALU: opnd_o = malu_i;
            FWD_MEM_LD:  opnd_o = mmo_i;
            default:     opnd_o = rf_i;
        endcase
    end

endmodule

// File: rtl/pipe_idex_stage.sv
// ID/EX pipeline register: forwards operands, detects load-use hazards,
// inserts bubbles on stall/flush and counts stall and flush events.
module pipe_idex_stage
    import pipe_idex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] dpc4,
    input  logic [XLEN-1:0] dqa,
    input  logic [XLEN-1:0] dqb,
    input  logic [XLEN-1:0] dimm,
    input  logic [RAW-1:0]  drs,
    input  logic [RAW-1:0]  drt,
    input  logic            drsuse,
    input  logic            drtuse,
    input  logic [RAW-1:0]  drn0,
    input  logic [3:0]      daluc,
    input  logic            daluimm,
    input  logic            dshift,
    input  logic            djal,
    input  logic            dwreg,
    input  logic            dm2reg,
    input  logic            dwmem,
    input  logic            dvalid,
    input  logic            dflush,
    input  logic [RAW-1:0]  ern,
    input  logic            ewreg_i,
    input  logic            em2reg_i,
    input  logic [XLEN-1:0] ealu,
    input  logic [RAW-1:0]  mrn,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [XLEN-1:0] malu,
    input  logic [XLEN-1:0] mmo,
    output logic            dstall,
    output logic [XLEN-1:0] ea,
    output logic [XLEN-1:0] eb,
    output logic [XLEN-1:0] eimm,
    output logic [XLEN-1:0] epc4,
    output logic [RAW-1:0]  ern0,
    output logic [3:0]      ealuc,
    output logic            ealuimm,
    output logic            eshift,
    output logic            ejal,
    output logic            ewreg,
    output logic            em2reg,
    output logic            ewmem,
    output logic            evalid,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    logic [XLEN-1:0] fwdA, fwdB;
    logic            hz, bubble;

    logic [XLEN-1:0] ea_d, ea_q, eb_d, eb_q, eimm_d, eimm_q, epc4_d, epc4_q;
    logic [RAW-1:0]  ern0_d, ern0_q;
    ctrl_t           ctrl_d, ctrl_q;
    logic [CNTW-1:0] stallCnt_d, stallCnt_q, flushCnt_d, flushCnt_q;

    pipe_fwd_sel #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs (
        .src_i(drs), .rf_i(dqa),
        .ern_i(ern), .ewreg_i(ewreg_i), .em2reg_i(em2reg_i), .ealu_i(ealu),
        .mrn_i(mrn), .mwreg_i(mwreg), .mm2reg_i(mm2reg), .malu_i(malu), .mmo_i(mmo),
        .opnd_o(fwdA)
    );

    pipe_fwd_sel #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rt (
        .src_i(drt), .rf_i(dqb),
        .ern_i(ern), .ewreg_i(ewreg_i), .em2reg_i(em2reg_i), .ealu_i(ealu),
        .mrn_i(mrn), .mwreg_i(mwreg), .mm2reg_i(mm2reg), .malu_i(malu), .mmo_i(mmo),
        .opnd_o(fwdB)
    );

    // Load-use hazard: a load in EX produces a register the decode slot really reads
    always_comb begin
        hz = dvalid & ewreg_i & em2reg_i & (ern != RAW'(REG_ZERO))
           & ((drsuse & (ern == drs)) | (drtuse & (ern == drt)));
        dstall = hz & ~dflush & ~rst;
        bubble = hz | dflush | ~dvalid;
    end

    // Next ID/EX contents: the decode slot, or an all-zero bubble
    always_comb begin
        ea_d   = '0;
        eb_d   = '0;
        eimm_d = '0;
        epc4_d = '0;
        ern0_d = '0;
        ctrl_d = CTRL_BUBBLE;
        if (!bubble) begin
            ea_d   = fwdA;
            eb_d   = fwdB;
            eimm_d = dimm;
            epc4_d = dpc4;
            ern0_d = drn0;
            ctrl_d = '{aluc: daluc, aluimm: daluimm, shift: dshift, jal: djal,
                       wreg: dwreg, m2reg: dm2reg, wmem: dwmem, valid: 1'b1};
        end
    end

    // Saturating event counters; they stick at all-ones rather than wrap
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (dstall && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNTW'(1);
        end
        if (dflush && dvalid && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + CNTW'(1);
        end
    end

    // Pipeline register and counters; EX always advances, no hold
    always_ff @(posedge clk) begin
        if (rst) begin
            ea_q       <= '0;
            eb_q       <= '0;
            eimm_q     <= '0;
            epc4_q     <= '0;
            ern0_q     <= '0;
            ctrl_q     <= CTRL_BUBBLE;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            eimm_q     <= eimm_d;
            epc4_q     <= epc4_d;
            ern0_q     <= ern0_d;
            ctrl_q     <= ctrl_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign ea        = ea_q;
    assign eb        = eb_q;
    assign eimm      = eimm_q;
    assign epc4      = epc4_q;
    assign ern0      = ern0_q;
    assign ealuc     = ctrl_q.aluc;
    assign ealuimm   = ctrl_q.aluimm;
    assign eshift    = ctrl_q.shift;
    assign ejal      = ctrl_q.jal;
    assign ewreg     = ctrl_q.wreg;
    assign em2reg    = ctrl_q.m2reg;
    assign ewmem     = ctrl_q.wmem;
    assign evalid    = ctrl_q.valid;
    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_pipe_idex_stage.sv
// Scoreboard bench for the ID/EX stage: stimulus pushes the expected
// register contents after each edge, a monitor pops and compares them.
module tb_pipe_idex_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int CNTW = 4;

    typedef struct packed {
        logic [31:0] ea, eb, eimm, epc4;
        logic [4:0]  ern0;
        logic [3:0]  aluc;
        logic [6:0]  ctrl;   // {aluimm, shift, jal, wreg, m2reg, wmem, valid}
        logic [15:0] sc, fc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] dpc4, dqa, dqb, dimm, ealu, malu, mmo;
    logic [RAW-1:0]  drs, drt, drn0, ern, mrn;
    logic            drsuse, drtuse, daluimm, dshift, djal, dwreg, dm2reg, dwmem;
    logic            dvalid, dflush, ewreg_i, em2reg_i, mwreg, mm2reg;
    logic [3:0]      daluc;
    logic            dstall;
    logic [XLEN-1:0] ea, eb, eimm, epc4;
    logic [RAW-1:0]  ern0;
    logic [3:0]      ealuc;
    logic            ealuimm, eshift, ejal, ewreg, em2reg, ewmem, evalid;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    pipe_idex_stage #(.XLEN(XLEN), .RAW(RAW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .dpc4(dpc4), .dqa(dqa), .dqb(dqb), .dimm(dimm),
        .drs(drs), .drt(drt), .drsuse(drsuse), .drtuse(drtuse), .drn0(drn0),
        .daluc(daluc), .daluimm(daluimm), .dshift(dshift), .djal(djal),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .dvalid(dvalid),
        .dflush(dflush), .ern(ern), .ewreg_i(ewreg_i), .em2reg_i(em2reg_i),
        .ealu(ealu), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu),
        .mmo(mmo), .dstall(dstall), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4),
        .ern0(ern0), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
        .ejal(ejal), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .evalid(evalid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] a, b, imm, pc4, input logic [4:0] rn,
                                   input logic [3:0] aluc, input logic [6:0] ctrl,
                                   input int sc, input int fc);
        exp_t e;
        e.ea = a; e.eb = b; e.eimm = imm; e.epc4 = pc4; e.ern0 = rn;
        e.aluc = aluc; e.ctrl = ctrl; e.sc = 16'(sc); e.fc = 16'(fc);
        return e;
    endfunction

    function automatic exp_t bubbleExp(input int sc, input int fc);
        return mkExp(0, 0, 0, 0, 0, 0, 7'b0, sc, fc);
    endfunction

    // Called just after the inputs are set on a falling edge
    task automatic applyStimulus(input logic expStall, input exp_t e);
        #1;
        checkOutput("dstall", 64'(dstall), 64'(expStall));
        expQ.push_back(e);
    endtask

    task automatic setIdle();
        dpc4 = 0; dqa = 0; dqb = 0; dimm = 0; ealu = 0; malu = 0; mmo = 0;
        drs = 0; drt = 0; drn0 = 0; ern = 0; mrn = 0;
        drsuse = 0; drtuse = 0; daluimm = 0; dshift = 0; djal = 0; dwreg = 0;
        dm2reg = 0; dwmem = 0; dvalid = 0; dflush = 0; ewreg_i = 0; em2reg_i = 0;
        mwreg = 0; mm2reg = 0; daluc = 0;
    endtask

    // Base decode slot: reads r1/r2, writes r7, ALU op 2
    task automatic setDecode();
        dpc4 = 32'h104; dqa = 32'h11; dqb = 32'h22; dimm = 32'h33;
        drs = 5'd1; drt = 5'd2; drsuse = 1; drtuse = 1; drn0 = 5'd7;
        daluc = 4'h2; dwreg = 1; dvalid = 1;
    endtask

    // EX holds a load to r5 that the decode slot's rs depends on
    task automatic setLoadUse();
        setDecode();
        dqa = 32'h55; drs = 5'd5; ern = 5'd5; ewreg_i = 1; em2reg_i = 1; ealu = 32'h99;
    endtask

    // Monitor: compare every pending expectation just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("ea",   64'(ea),   64'(e.ea));
                checkOutput("eb",   64'(eb),   64'(e.eb));
                checkOutput("eimm", 64'(eimm), 64'(e.eimm));
                checkOutput("epc4", 64'(epc4), 64'(e.epc4));
                checkOutput("ern0", 64'(ern0), 64'(e.ern0));
                checkOutput("ealuc", 64'(ealuc), 64'(e.aluc));
                checkOutput("ctrl", 64'({ealuimm, eshift, ejal, ewreg, em2reg, ewmem, evalid}),
                            64'(e.ctrl));
                checkOutput("stall_cnt", 64'(stall_cnt), 64'(e.sc));
                checkOutput("flush_cnt", 64'(flush_cnt), 64'(e.fc));
            end
        end
    end

    initial begin
        int sc;
        int waitCycles;
        setIdle();
        rst = 1;

        // Reset with a live load-use pattern: dstall must stay low
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); setLoadUse();
            applyStimulus(1'b0, bubbleExp(0, 0));
        end

        @(negedge clk); rst = 0; setIdle(); setDecode();
        daluimm = 1; dshift = 1; djal = 1; dm2reg = 1; dwmem = 1;
        applyStimulus(1'b0, mkExp(32'h11, 32'h22, 32'h33, 32'h104, 7, 2, 7'b1111111, 0, 0));

        // EX forward of r3
        @(negedge clk); setIdle(); setDecode();
        drs = 5'd3; dqa = 32'h5; ern = 5'd3; ewreg_i = 1; ealu = 32'h10;
        applyStimulus(1'b0, mkExp(32'h10, 32'h22, 32'h33, 32'h104, 7, 2, 7'b0001001, 0, 0));

        // EX and MEM both target r3: EX wins
        @(negedge clk); mrn = 5'd3; mwreg = 1; malu = 32'h20;
        applyStimulus(1'b0, mkExp(32'h10, 32'h22, 32'h33, 32'h104, 7, 2, 7'b0001001, 0, 0));

        // MEM ALU only
        @(negedge clk); ewreg_i = 0;
        applyStimulus(1'b0, mkExp(32'h20, 32'h22, 32'h33, 32'h104, 7, 2, 7'b0001001, 0, 0));

        // MEM load forward onto rt
        @(negedge clk); setIdle(); setDecode();
        drt = 5'd4; mrn = 5'd4; mwreg = 1; mm2reg = 1; mmo = 32'hDEAD_BEEF; malu = 32'h20;
        applyStimulus(1'b0, mkExp(32'h11, 32'hDEAD_BEEF, 32'h33, 32'h104, 7, 2, 7'b0001001, 0, 0));

        // r0 never forwards from EX or MEM
        @(negedge clk); setIdle(); setDecode();
        drs = 0; drt = 0; ern = 0; ewreg_i = 1; ealu = 32'h10;
        mrn = 0; mwreg = 1; malu = 32'h20;
        applyStimulus(1'b0, mkExp(32'h11, 32'h22, 32'h33, 32'h104, 7, 2, 7'b0001001, 0, 0));

        // Load-use: stall one cycle, bubble goes to EX
        @(negedge clk); setIdle(); setLoadUse(); drn0 = 5'd8;
        applyStimulus(1'b1, bubbleExp(1, 0));

        // Re-presented: load now in MEM supplies mmo
        @(negedge clk); ern = 0; ewreg_i = 0; em2reg_i = 0;
        mrn = 5'd5; mwreg = 1; mm2reg = 1; mmo = 32'hCAFE_0001;
        applyStimulus(1'b0, mkExp(32'hCAFE_0001, 32'h22, 32'h33, 32'h104, 8, 2, 7'b0001001, 1, 0));

        // Flush together with a load-use match: flush wins
        @(negedge clk); setIdle(); setLoadUse(); dflush = 1;
        applyStimulus(1'b0, bubbleExp(1, 1));

        // Flush of an empty slot does not count
        @(negedge clk); dvalid = 0;
        applyStimulus(1'b0, bubbleExp(1, 1));

        // Load target matches rs but rs is not read: no hazard, no forward
        @(negedge clk); setIdle(); setLoadUse(); drsuse = 0;
        applyStimulus(1'b0, mkExp(32'h55, 32'h22, 32'h33, 32'h104, 7, 2, 7'b0001001, 1, 1));

        // Empty decode slot with a match: bubble, no stall
        @(negedge clk); drsuse = 1; dvalid = 0;
        applyStimulus(1'b0, bubbleExp(1, 1));

        // Saturation: 19 consecutive stalls on a 4-bit counter
        sc = 1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk); setIdle(); setLoadUse();
            sc = (sc < 15) ? sc + 1 : 15;
            applyStimulus(1'b1, bubbleExp(sc, 1));
        end

        // Reset while stalling: dstall drops at once, next edge clears everything
        @(negedge clk); rst = 1;
        applyStimulus(1'b0, bubbleExp(0, 0));

        @(negedge clk); rst = 0; setIdle(); setDecode();
        applyStimulus(1'b0, mkExp(32'h11, 32'h22, 32'h33, 32'h104, 7, 2, 7'b0001001, 0, 0));

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
